// File: rtl/dev_uart_rx.sv
// dev_uart_rx -- 8N1 serial byte receiver, LSB first.
//
// Converts the asynchronous RX pin into a held byte plus a one-cycle strobe.
// The last correctly framed byte stays on `data` until the next good byte
// arrives.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   start-bit enable; a frame already in progress completes
//   rx         in   asynchronous serial input, idles high
//   data       out  last correctly framed byte
//   valid      out  one-cycle pulse when `data` is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high in every state except IDLE
module dev_uart_rx #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state_q;
   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    sh_q;
   logic [7:0]    data_q;
   logic          valid_q, ferr_q, busy_q;
   logic          rx_s;

   assign rx_s      = sync2_q;
   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         // strobes are single-cycle unless re-asserted below
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (en && !rx_s) begin
                  cnt_q   <= '0;
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the line half a bit in; a short low pulse is a glitch.
            START: begin
               if (cnt_q == HALF_LAST) begin
                  if (rx_s) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // Sampling is anchored to the start-bit centre, so each sample
            // lands mid-bit. Right shift leaves the first bit in sh_q[0].
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  sh_q  <= {rx_s, sh_q[7:1]};
                  idx_q <= idx_q + 3'd1;
                  if (idx_q == 3'd7)
                     state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // Leaving at mid-stop-bit lets a directly following start edge
            // be caught from IDLE.
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     data_q  <= sh_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // A line stuck low must return high before a new start is seen.
            BREAK: begin
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dev_uart_rx.sv
// Bench for dev_uart_rx: directed frames with a scoreboard queue. Stimulus
// pushes the expected strobe (kind, data, cycle) and a negedge monitor pops
// and compares whenever valid or frame_err is seen.
module tb_dev_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n, en, rx;
   logic [7:0] data;
   logic       valid, frame_err, busy;

   dev_uart_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      bit         err;
      longint     t;   // expected cycle of the strobe, -1 = don't care
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   int         tests = 0;
   int         fails = 0;
   logic [7:0] last_data = 8'h00;

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (valid === 1'b1 || frame_err === 1'b1)) begin
         if (valid && frame_err) chk("strobe_exclusive", 32'd1, 32'd0);
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%h at cycle %0d, expected no pulse",
                     valid, frame_err, data, cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("strobe_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e.err});
            chk("strobe_data", {24'd0, data}, {24'd0, mon_e.d});
            if (mon_e.t >= 0) begin
               tests++;
               if (cyc < mon_e.t - 1 || cyc > mon_e.t + 1) begin
                  fails++;
                  $display("FAIL strobe_time: got cycle %0d, expected %0d +-1", cyc, mon_e.t);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame; caller is positioned 1 time unit after a clock edge.
   task automatic send(input logic [7:0] b, input int per, input bit stop,
                       input bit expect_it, input bit drop_en);
      logic [9:0] fr;
      exp_t       e;
      fr = {stop, b, 1'b0};
      if (expect_it) begin
         e.d   = stop ? b : last_data;
         e.err = !stop;
         e.t   = (per == 104) ? cyc + 991 : -1;
         sbq.push_back(e);
         if (stop) last_data = b;
      end
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         idle(per);
         if (i == 0 && drop_en) en = 1'b0;
      end
   endtask

   logic [7:0] v;

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, data}, 32'h00);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      idle(5);

      // single frame, checked for latency by the monitor
      send(8'hA5, 104, 1'b1, 1'b1, 1'b0);
      idle(20);
      chk("a5_busy_after", {31'd0, busy}, 32'd0);
      chk("a5_data", {24'd0, data}, 32'hA5);

      // back-to-back frames, no idle gap
      send(8'h00, 104, 1'b1, 1'b1, 1'b0);
      send(8'hFF, 104, 1'b1, 1'b1, 1'b0);
      idle(20);
      chk("b2b_data", {24'd0, data}, 32'hFF);

      // 20-cycle glitch
      rx = 1'b0;
      idle(20);
      rx = 1'b1;
      idle(10);
      chk("glitch_busy_mid", {31'd0, busy}, 32'd1);
      idle(40);
      chk("glitch_busy_end", {31'd0, busy}, 32'd0);
      chk("glitch_data", {24'd0, data}, 32'hFF);

      // framing error, line held low, then a good frame
      send(8'h3C, 104, 1'b0, 1'b1, 1'b0);
      idle(500);
      chk("break_busy", {31'd0, busy}, 32'd1);
      chk("ferr_data_kept", {24'd0, data}, 32'hFF);
      rx = 1'b1;
      idle(20);
      chk("break_exit_busy", {31'd0, busy}, 32'd0);
      send(8'h42, 104, 1'b1, 1'b1, 1'b0);
      idle(20);
      chk("after_break_data", {24'd0, data}, 32'h42);

      // reset during data bit 4 of 0x99
      v  = 8'h99;
      rx = 1'b0;
      idle(104);
      for (int i = 0; i < 4; i++) begin
         rx = v[i];
         idle(104);
      end
      rx = v[4];
      idle(50);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_data = 8'h00;
      chk("midrst_data", {24'd0, data}, 32'h00);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      idle(1200);
      chk("midrst_data_hold", {24'd0, data}, 32'h00);
      send(8'h17, 104, 1'b1, 1'b1, 1'b0);
      idle(20);
      chk("post_rst_data", {24'd0, data}, 32'h17);

      // baud mismatch, fast then slow transmitter
      send(8'h5A, 101, 1'b1, 1'b1, 1'b0);
      idle(200);
      chk("fast_tx_data", {24'd0, data}, 32'h5A);
      send(8'h00, 104, 1'b1, 1'b1, 1'b0);
      idle(50);
      send(8'h5A, 107, 1'b1, 1'b1, 1'b0);
      idle(200);
      chk("slow_tx_data", {24'd0, data}, 32'h5A);

      // en dropped after start is accepted: frame still completes
      send(8'hC3, 104, 1'b1, 1'b1, 1'b1);
      idle(20);
      chk("en_drop_data", {24'd0, data}, 32'hC3);

      // en low: whole frame ignored
      en = 1'b0;
      rx = 1'b0;
      idle(104);
      chk("en0_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      idle(50);
      send(8'h81, 104, 1'b1, 1'b0, 1'b0);
      idle(50);
      chk("en0_data", {24'd0, data}, 32'hC3);
      en = 1'b1;
      idle(20);

      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
